coproc_job_responder: RTL and testbench

//  Host-side counterpart of the coprocessor job protocol. On a host start it:
//   - fetches the config word from memory;
//   - presents (row, col, mu) with the index handshake;
//   - grants the coprocessor the memory bus and proxies its reads/writes to the single-port memory;
//   - reports completion when the coprocessor raises result_ready.

---
 rtl/coproc_pkg.sv | 33 +++
 rtl/sat_counter.sv | 22 ++
 rtl/coproc_job_responder.sv | 160 ++++++++++++++++
 tb/tb_coproc_job_responder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/coproc_pkg.sv
// Shared state encoding and config-word field layout for the coprocessor job responder.
package coproc_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CFG_RD   = 3'd1;
  localparam logic [2:0] ST_CFG_WAIT = 3'd2;
  localparam logic [2:0] ST_ISSUE    = 3'd3;
  localparam logic [2:0] ST_SERVE    = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;
  localparam logic [2:0] ST_ERROR    = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE     = ST_IDLE,
    S_CFG_RD   = ST_CFG_RD,
    S_CFG_WAIT = ST_CFG_WAIT,
    S_ISSUE    = ST_ISSUE,
    S_SERVE    = ST_SERVE,
    S_DONE     = ST_DONE,
    S_ERROR    = ST_ERROR
  } state_t;

  localparam int unsigned FIELD_W    = 8;
  localparam int unsigned MU_LSB     = 16;
  localparam int unsigned GAMMA_LSB  = 8;
  localparam int unsigned LAMBDA_LSB = 0;

  // Extract one 8-bit field from the 32-bit config word.
  function automatic logic [FIELD_W-1:0] cfg_field(input logic [31:0] cfg,
                                                   input int unsigned lsb);
    return cfg[lsb +: FIELD_W];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int unsigned width = 16
) (
  input  logic             in_clk,
  input  logic             in_reset,
  input  logic             clear,
  input  logic             inc,
  output logic [width-1:0] count
);

  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + width'(1);
    end
  end

endmodule

// File: rtl/coproc_job_responder.sv
// Host-side job responder: config fetch, index handshake, bus proxy and watchdog.
// Optional PERF_CNT_EN adds saturating read/write/busy-cycle counters.
module coproc_job_responder
  import coproc_pkg::*;
#(
  parameter int unsigned size            = 3,
  parameter int unsigned cell_width      = 32,
  parameter int unsigned index_width     = 8,
  parameter int unsigned width           = cell_width * size,
  parameter int unsigned memory_size_log = 8,
  parameter int unsigned config_address  = 0,
  parameter int unsigned timeout_cycles  = 4096
) (
  input  logic                       in_clk,
  input  logic                       in_reset,
  input  logic                       in_start,
  input  logic [index_width-1:0]     in_row_index,
  input  logic [index_width-1:0]     in_col_index,
  output logic                       out_busy,
  output logic                       out_done,
  output logic                       out_error,
  output logic [cell_width-1:0]      out_config,
  output logic [index_width-1:0]     out_row_index,
  output logic [index_width-1:0]     out_col_index,
  output logic [index_width-1:0]     out_mu,
  output logic                       out_index_ready,
  input  logic                       in_index_ack,
  input  logic                       in_request,
  output logic                       out_grant,
  input  logic                       in_result_ready,
  input  logic                       in_cp_mem_read_en,
  input  logic                       in_cp_mem_write_en,
  input  logic [memory_size_log-1:0] in_cp_mem_address,
  input  logic [width-1:0]           in_cp_mem_data,
  output logic [memory_size_log-1:0] out_mem_address,
  output logic [width-1:0]           out_mem_data,
  output logic                       out_mem_read_en,
  output logic                       out_mem_write_en,
  input  logic [width-1:0]           in_mem_data
`ifdef PERF_CNT_EN
  ,
  output logic [15:0]                out_rd_count,
  output logic [15:0]                out_wr_count,
  output logic [15:0]                out_cycle_count
`endif
);

  localparam int unsigned WD_W = $clog2(timeout_cycles + 1);

  state_t            state;
  logic              proxy_rd;
  logic              proxy_wr;
  logic              wd_clear;
  logic              wd_inc;
  logic              timeout_hit;
  logic [WD_W-1:0]   wd_count;
  logic              unused_bits;

  assign unused_bits = ^in_mem_data[width-1:cell_width];

  // Grant, index_ready and strobes are gated by reset so they drop in the reset cycle itself.
  assign out_grant       = (state == S_SERVE) && in_request && !in_reset;
  assign out_index_ready = (state == S_ISSUE) && !in_reset;
  assign proxy_wr        = out_grant && in_cp_mem_write_en;
  assign proxy_rd        = out_grant && in_cp_mem_read_en && !in_cp_mem_write_en;

  always_comb begin
    out_mem_address  = '0;
    out_mem_data     = '0;
    out_mem_read_en  = 1'b0;
    out_mem_write_en = 1'b0;
    if ((state == S_CFG_RD) && !in_reset) begin
      out_mem_read_en = 1'b1;
      out_mem_address = memory_size_log'(config_address);
    end else if (out_grant) begin
      out_mem_address  = in_cp_mem_address;
      out_mem_data     = in_cp_mem_data;
      out_mem_read_en  = proxy_rd;
      out_mem_write_en = proxy_wr;
    end
  end

  // Watchdog: cleared as SERVE is entered, trips on the timeout_cycles-th SERVE cycle.
  assign wd_clear    = (state == S_ISSUE) && in_index_ack;
  assign wd_inc      = (state == S_SERVE);
  assign timeout_hit = (wd_count == WD_W'(timeout_cycles - 1));

  sat_counter #(.width(WD_W)) u_watchdog (
    .in_clk   (in_clk),
    .in_reset (in_reset),
    .clear    (wd_clear),
    .inc      (wd_inc),
    .count    (wd_count)
  );

  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      state         <= S_IDLE;
      out_busy      <= 1'b0;
      out_done      <= 1'b0;
      out_error     <= 1'b0;
      out_config    <= '0;
      out_row_index <= '0;
      out_col_index <= '0;
      out_mu        <= '0;
    end else begin
      out_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_start) begin
            out_row_index <= in_row_index;
            out_col_index <= in_col_index;
            out_error     <= 1'b0;
            out_busy      <= 1'b1;
            state         <= S_CFG_RD;
          end
        end
        S_CFG_RD:   state <= S_CFG_WAIT;
        S_CFG_WAIT: begin
          out_config <= in_mem_data[cell_width-1:0];
          out_mu     <= index_width'(cfg_field(32'(in_mem_data[cell_width-1:0]), MU_LSB));
          state      <= S_ISSUE;
        end
        S_ISSUE: begin
          if (in_index_ack) state <= S_SERVE;
        end
        S_SERVE: begin
          if (in_result_ready) begin
            out_busy <= 1'b0;
            out_done <= 1'b1;
            state    <= S_DONE;
          end else if (timeout_hit) begin
            out_busy  <= 1'b0;
            out_error <= 1'b1;
            state     <= S_ERROR;
          end
        end
        S_DONE:  state <= S_IDLE;
        S_ERROR: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef PERF_CNT_EN
  logic perf_clear;
  assign perf_clear = (state == S_IDLE) && in_start && !in_reset;

  sat_counter #(.width(16)) u_rd_cnt (
    .in_clk(in_clk), .in_reset(in_reset), .clear(perf_clear), .inc(proxy_rd), .count(out_rd_count)
  );
  sat_counter #(.width(16)) u_wr_cnt (
    .in_clk(in_clk), .in_reset(in_reset), .clear(perf_clear), .inc(proxy_wr), .count(out_wr_count)
  );
  sat_counter #(.width(16)) u_cyc_cnt (
    .in_clk(in_clk), .in_reset(in_reset), .clear(perf_clear), .inc(out_busy), .count(out_cycle_count)
  );
`endif

endmodule

// File: tb/tb_coproc_job_responder.sv
// Directed bench for coproc_job_responder with a small behavioural single-port memory.
module tb_coproc_job_responder;

  logic        clk = 1'b0;
  logic        in_reset, in_start;
  logic [7:0]  in_row_index, in_col_index;
  logic        out_busy, out_done, out_error;
  logic [31:0] out_config;
  logic [7:0]  out_row_index, out_col_index, out_mu;
  logic        out_index_ready, in_index_ack, in_request, out_grant, in_result_ready;
  logic        in_cp_mem_read_en, in_cp_mem_write_en;
  logic [7:0]  in_cp_mem_address;
  logic [95:0] in_cp_mem_data;
  logic [7:0]  out_mem_address;
  logic [95:0] out_mem_data;
  logic        out_mem_read_en, out_mem_write_en;
  logic [95:0] in_mem_data;
`ifdef PERF_CNT_EN
  logic [15:0] out_rd_count, out_wr_count, out_cycle_count;
`endif

  logic [95:0] mem [256];
  logic        pre_we;
  logic [7:0]  pre_a;
  logic [95:0] pre_d;
  int          total = 0;
  int          bad = 0;
  int          n;

  always #5 clk = ~clk;

  coproc_job_responder dut (
    .in_clk(clk), .in_reset(in_reset), .in_start(in_start),
    .in_row_index(in_row_index), .in_col_index(in_col_index),
    .out_busy(out_busy), .out_done(out_done), .out_error(out_error),
    .out_config(out_config), .out_row_index(out_row_index), .out_col_index(out_col_index),
    .out_mu(out_mu), .out_index_ready(out_index_ready), .in_index_ack(in_index_ack),
    .in_request(in_request), .out_grant(out_grant), .in_result_ready(in_result_ready),
    .in_cp_mem_read_en(in_cp_mem_read_en), .in_cp_mem_write_en(in_cp_mem_write_en),
    .in_cp_mem_address(in_cp_mem_address), .in_cp_mem_data(in_cp_mem_data),
    .out_mem_address(out_mem_address), .out_mem_data(out_mem_data),
    .out_mem_read_en(out_mem_read_en), .out_mem_write_en(out_mem_write_en),
    .in_mem_data(in_mem_data)
`ifdef PERF_CNT_EN
    , .out_rd_count(out_rd_count), .out_wr_count(out_wr_count), .out_cycle_count(out_cycle_count)
`endif
  );

  // Memory: one-cycle read latency, preload port for the bench.
  always @(posedge clk) begin
    if (pre_we) mem[pre_a] <= pre_d;
    else if (out_mem_write_en) mem[out_mem_address] <= out_mem_data;
    if (out_mem_read_en) in_mem_data <= mem[out_mem_address];
  end

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [7:0] r, input logic [7:0] c);
    in_row_index = r;
    in_col_index = c;
    in_start = 1'b1;
    tick();
    in_start = 1'b0;
  endtask

  initial begin
    in_reset = 1'b1; in_start = 1'b1; in_row_index = 8'h11; in_col_index = 8'h22;
    in_index_ack = 0; in_request = 0; in_result_ready = 0;
    in_cp_mem_read_en = 0; in_cp_mem_write_en = 0; in_cp_mem_address = 0; in_cp_mem_data = 0;
    in_mem_data = '0;
    pre_we = 1'b1; pre_a = 8'd0; pre_d = 96'h0005_0302;
    tick();
    pre_a = 8'd3; pre_d = {3{32'h3333_3333}};
    tick();
    pre_a = 8'd12; pre_d = '0;
    tick();
    pre_we = 1'b0;
    chk("rst_busy", out_busy, 0);
    chk("rst_grant", out_grant, 0);
    chk("rst_rd_en", out_mem_read_en, 0);
    in_reset = 1'b0; in_start = 1'b0;
    tick();
    chk("post_rst_busy", out_busy, 0);
    chk("post_rst_cfg", out_config, 0);
    chk("post_rst_row", out_row_index, 0);

    // Job 1: config fetch, handshake, proxied read/write
    start_job(8'd0, 8'd1);
    chk("j1_busy", out_busy, 1);
    chk("cfg_rd_en", out_mem_read_en, 1);
    chk("cfg_addr", out_mem_address, 0);
    tick();
    tick();
    chk("cfg_word", out_config, 32'h0005_0302);
    chk("cfg_mu", out_mu, 8'h05);
    chk("idx_rdy", out_index_ready, 1);
    chk("col_out", out_col_index, 1);
    tick();
    chk("idx_rdy_hold", out_index_ready, 1);
    in_index_ack = 1'b1;
    tick();
    in_index_ack = 1'b0;
    chk("idx_rdy_drop", out_index_ready, 0);
    chk("grant_noreq", out_grant, 0);
    in_request = 1'b1; in_cp_mem_read_en = 1'b1; in_cp_mem_address = 8'h03;
    #1;
    chk("grant_req", out_grant, 1);
    chk("prx_rd_en", out_mem_read_en, 1);
    chk("prx_rd_addr", out_mem_address, 8'h03);
    tick();
    in_cp_mem_read_en = 1'b0; in_cp_mem_write_en = 1'b1;
    in_cp_mem_address = 8'h06; in_cp_mem_data = {12{8'hAA}};
    #1;
    chk("prx_rdata", in_mem_data, {3{32'h3333_3333}});
    chk("prx_wr_en", out_mem_write_en, 1);
    chk("prx_wr_data", out_mem_data, {12{8'hAA}});
    tick();
    chk("mem6", mem[6], {12{8'hAA}});
    in_cp_mem_read_en = 1'b1; in_cp_mem_address = 8'h07; in_cp_mem_data = {12{8'hBB}};
    #1;
    chk("both_rd_en", out_mem_read_en, 0);
    chk("both_wr_en", out_mem_write_en, 1);
    tick();
    in_cp_mem_read_en = 0; in_cp_mem_write_en = 0; in_request = 0; in_result_ready = 1'b1;
    tick();
    in_result_ready = 1'b0;
    chk("j1_done", out_done, 1);
    chk("j1_done_busy", out_busy, 0);
    chk("j1_done_grant", out_grant, 0);
`ifdef PERF_CNT_EN
    chk("j1_rd_cnt", out_rd_count, 1);
    chk("j1_wr_cnt", out_wr_count, 2);
`endif
    tick();
    chk("j1_done_pulse", out_done, 0);

    // Job 2: plain completion
    start_job(8'd2, 8'd4);
    tick();
    tick();
    chk("j2_row", out_row_index, 2);
    chk("j2_col", out_col_index, 4);
    in_index_ack = 1'b1;
    tick();
    in_index_ack = 1'b0; in_request = 1'b1; in_result_ready = 1'b1;
    tick();
    in_result_ready = 1'b0; in_request = 1'b0;
    chk("j2_done", out_done, 1);
    tick();

    // Job 3: watchdog timeout with request held
    start_job(8'd5, 8'd6);
    tick();
    tick();
    in_index_ack = 1'b1;
    tick();
    in_index_ack = 1'b0; in_request = 1'b1;
    n = 0;
    while (!out_error && n < 5000) begin
      tick();
      n++;
    end
    chk("wd_cycles", n, 4096);
    chk("wd_error", out_error, 1);
    chk("wd_grant", out_grant, 0);
    chk("wd_busy", out_busy, 0);
    in_request = 1'b0;
    tick();
    chk("wd_sticky", out_error, 1);

    // Job 4: error clear, counters, reset mid-SERVE with a write pending
    start_job(8'd7, 8'd9);
    chk("err_clear", out_error, 0);
    tick();
    tick();
    in_index_ack = 1'b1;
    tick();
    in_index_ack = 1'b0; in_request = 1'b1; in_cp_mem_read_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_cp_mem_address = 8'(i);
      tick();
    end
    in_cp_mem_read_en = 1'b0; in_cp_mem_write_en = 1'b1; in_cp_mem_data = {12{8'h5A}};
    for (int i = 10; i <= 11; i++) begin
      in_cp_mem_address = 8'(i);
      tick();
    end
`ifdef PERF_CNT_EN
    chk("j4_rd_cnt", out_rd_count, 3);
    chk("j4_wr_cnt", out_wr_count, 2);
`endif
    in_cp_mem_address = 8'd12; in_cp_mem_data = {12{8'hCC}}; in_reset = 1'b1;
    #1;
    chk("rst_serve_wr", out_mem_write_en, 0);
    chk("rst_serve_grant", out_grant, 0);
    tick();
    in_reset = 1'b0; in_cp_mem_write_en = 1'b0; in_request = 1'b0;
    tick();
    chk("rst_mem12", mem[12], 0);
    chk("rst_idle_busy", out_busy, 0);
    chk("rst_idle_idx", out_index_ready, 0);
    chk("rst_idle_err", out_error, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
